// File: rtl/bf16_to_int_cvt_if.sv
// Valid/ready handshake bundle between a requester and the bfloat16-to-integer converter.
// Signal suffixes are seen from the converter side.
interface bf16_to_int_cvt_if;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] operand_i;
    logic        signed_i;
    logic [2:0]  rm_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        nv_o;
    logic        nx_o;

    modport master (
        output valid_i, operand_i, signed_i, rm_i, ready_i,
        input  ready_o, valid_o, result_o, nv_o, nx_o
    );

    modport slave (
        input  valid_i, operand_i, signed_i, rm_i, ready_i,
        output ready_o, valid_o, result_o, nv_o, nx_o
    );
endinterface

// File: rtl/bf16_to_int_cvt.sv
// Iterative bfloat16 -> int32/uint32 converter (FCVT.W.BF16 / FCVT.WU.BF16).
// Alignment uses a one-bit-per-cycle shifter; rounding and range check happen in one cycle.
module bf16_to_int_cvt #(
    parameter int unsigned INT_W = 32
) (
    input logic             clk_i,
    input logic             rst_ni,
    bf16_to_int_cvt_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StRound, StDone} state_e;

    state_e             state_q, state_d;
    logic [INT_W-1:0]   mag_q, mag_d;
    logic               g_q, g_d;
    logic               st_q, st_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               left_q, left_d;
    logic               neg_q, neg_d;
    logic               sgn_q, sgn_d;
    logic [2:0]         rm_q, rm_d;
    logic               spec_q, spec_d;
    logic [INT_W-1:0]   result_q, result_d;
    logic               nv_q, nv_d;
    logic               nx_q, nx_d;

    logic               op_s;
    logic [7:0]         op_e;
    logic [6:0]         op_m;
    logic               inc;
    logic [INT_W:0]     sum;

    assign op_s = bus.operand_i[15];
    assign op_e = bus.operand_i[14:7];
    assign op_m = bus.operand_i[6:0];

    always_comb begin
        inc = 1'b0;
        unique case (rm_q)
            3'b000:  inc = g_q & (st_q | mag_q[0]);
            3'b010:  inc = neg_q & (g_q | st_q);
            3'b011:  inc = ~neg_q & (g_q | st_q);
            3'b100:  inc = g_q;
            default: inc = 1'b0;
        endcase
    end

    // g=st=0 whenever the magnitude was shifted left, so the top bit of sum never sets.
    assign sum = {1'b0, mag_q} + {{INT_W{1'b0}}, inc};

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        g_d      = g_q;
        st_d     = st_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        neg_d    = neg_q;
        sgn_d    = sgn_q;
        rm_d     = rm_q;
        spec_d   = spec_q;
        result_d = result_q;
        nv_d     = nv_q;
        nx_d     = nx_q;

        unique case (state_q)
            StIdle: begin
                if (bus.valid_i) begin
                    state_d = StShift;
                    neg_d   = op_s;
                    sgn_d   = bus.signed_i;
                    rm_d    = bus.rm_i;
                    mag_d   = {{(INT_W-8){1'b0}}, 1'b1, op_m};
                    g_d     = 1'b0;
                    st_d    = 1'b0;
                    cnt_d   = 5'd0;
                    left_d  = 1'b0;
                    spec_d  = 1'b0;
                    nv_d    = 1'b0;
                    nx_d    = 1'b0;
                    if (op_e == 8'hFF) begin
                        spec_d = 1'b1;
                        nv_d   = 1'b1;
                        if (op_m != 7'd0 || !op_s) begin
                            result_d = bus.signed_i ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
                        end else begin
                            result_d = bus.signed_i ? 32'h8000_0000 : 32'h0000_0000;
                        end
                    end else if (op_e == 8'h00) begin
                        mag_d = '0;
                        st_d  = (op_m != 7'd0);
                    end else if (op_e < 8'd126) begin
                        mag_d = '0;
                        st_d  = 1'b1;
                    end else if (bus.signed_i && op_e >= 8'd158) begin
                        spec_d = 1'b1;
                        if (op_s && op_e == 8'd158 && op_m == 7'd0) begin
                            result_d = 32'h8000_0000;
                        end else begin
                            nv_d     = 1'b1;
                            result_d = op_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        end
                    end else if (!bus.signed_i && op_e >= 8'd159) begin
                        spec_d   = 1'b1;
                        nv_d     = 1'b1;
                        result_d = op_s ? 32'h0000_0000 : 32'hFFFF_FFFF;
                    end else if (op_e >= 8'd134) begin
                        left_d = 1'b1;
                        cnt_d  = 5'(op_e - 8'd134);
                    end else begin
                        cnt_d  = 5'(8'd134 - op_e);
                    end
                end
            end
            StShift: begin
                if (cnt_q == 5'd0) begin
                    state_d = StRound;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                    if (left_q) begin
                        mag_d = mag_q << 1;
                    end else begin
                        st_d  = st_q | g_q;
                        g_d   = mag_q[0];
                        mag_d = mag_q >> 1;
                    end
                end
            end
            StRound: begin
                state_d = StDone;
                if (!spec_q) begin
                    nv_d = 1'b0;
                    if (sgn_q) begin
                        if (!neg_q && sum > 33'h0_7FFF_FFFF) begin
                            result_d = 32'h7FFF_FFFF;
                            nv_d     = 1'b1;
                        end else if (neg_q && sum > 33'h0_8000_0000) begin
                            result_d = 32'h8000_0000;
                            nv_d     = 1'b1;
                        end else begin
                            result_d = neg_q ? -sum[INT_W-1:0] : sum[INT_W-1:0];
                        end
                    end else if (neg_q && sum != '0) begin
                        result_d = '0;
                        nv_d     = 1'b1;
                    end else begin
                        result_d = sum[INT_W-1:0];
                    end
                    nx_d = (g_q | st_q) & ~nv_d;
                end
            end
            StDone: begin
                if (bus.ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            mag_q    <= '0;
            g_q      <= 1'b0;
            st_q     <= 1'b0;
            cnt_q    <= 5'd0;
            left_q   <= 1'b0;
            neg_q    <= 1'b0;
            sgn_q    <= 1'b0;
            rm_q     <= 3'd0;
            spec_q   <= 1'b0;
            result_q <= '0;
            nv_q     <= 1'b0;
            nx_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            g_q      <= g_d;
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            neg_q    <= neg_d;
            sgn_q    <= sgn_d;
            rm_q     <= rm_d;
            spec_q   <= spec_d;
            result_q <= result_d;
            nv_q     <= nv_d;
            nx_q     <= nx_d;
        end
    end

    assign bus.ready_o  = (state_q == StIdle);
    assign bus.valid_o  = (state_q == StDone);
    assign bus.result_o = result_q;
    assign bus.nv_o     = nv_q;
    assign bus.nx_o     = nx_q;

endmodule

// File: tb/tb_bf16_to_int_cvt.sv
// Directed table-driven bench for bf16_to_int_cvt plus backpressure and reset sequences.
module tb_bf16_to_int_cvt;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    bf16_to_int_cvt_if bus ();

    bf16_to_int_cvt #(.INT_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        logic        sgn;
        logic [2:0]  rm;
        logic [31:0] res;
        logic        nv;
        logic        nx;
        int          lat;  // -1: latency not checked
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [15:0] op, input logic sgn, input logic [2:0] rm,
                                input logic [31:0] res, input logic nv, input logic nx,
                                input int lat);
        vec_t v;
        v.op = op; v.sgn = sgn; v.rm = rm; v.res = res; v.nv = nv; v.nx = nx; v.lat = lat;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Accepts one operand and waits (bounded) for valid_o; does not complete the handshake.
    task automatic run_op(input logic [15:0] op, input logic sgn, input logic [2:0] rm,
                          output logic got, output logic [31:0] res, output logic nv,
                          output logic nx, output int lat);
        for (int i = 0; i < 60 && !bus.ready_o; i++) begin
            @(posedge clk); #1;
        end
        bus.valid_i   = 1'b1;
        bus.operand_i = op;
        bus.signed_i  = sgn;
        bus.rm_i      = rm;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        lat = 0;
        while (!bus.valid_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got = bus.valid_o;
        res = bus.result_o;
        nv  = bus.nv_o;
        nx  = bus.nx_o;
    endtask

    initial begin
        logic        got, nv, nx;
        logic [31:0] res;
        int          lat;
        logic        stray;

        bus.valid_i   = 1'b0;
        bus.operand_i = 16'h0;
        bus.signed_i  = 1'b0;
        bus.rm_i      = 3'd0;
        bus.ready_i   = 1'b1;

        add(16'h4049, 1'b1, 3'd0, 32'h0000_0003, 1'b0, 1'b1, 8);
        add(16'h3FC0, 1'b1, 3'd0, 32'h0000_0002, 1'b0, 1'b1, 9);
        add(16'h4020, 1'b1, 3'd0, 32'h0000_0002, 1'b0, 1'b1, -1);
        add(16'h4020, 1'b1, 3'd4, 32'h0000_0003, 1'b0, 1'b1, -1);
        add(16'h4020, 1'b1, 3'd1, 32'h0000_0002, 1'b0, 1'b1, -1);
        add(16'h4020, 1'b1, 3'd3, 32'h0000_0003, 1'b0, 1'b1, -1);
        add(16'h4020, 1'b1, 3'd5, 32'h0000_0002, 1'b0, 1'b1, -1);
        add(16'hCF00, 1'b1, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 2);
        add(16'h4F00, 1'b1, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
        add(16'h4F00, 1'b0, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 26);
        add(16'h7FC0, 1'b1, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
        add(16'hFFC0, 1'b0, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 2);
        add(16'hFF80, 1'b0, 3'd0, 32'h0000_0000, 1'b1, 1'b0, 2);
        add(16'hFF80, 1'b1, 3'd0, 32'h8000_0000, 1'b1, 1'b0, 2);
        add(16'h7F80, 1'b0, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 2);
        add(16'hBF00, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 1'b1, 10);
        add(16'hBF00, 1'b0, 3'd2, 32'h0000_0000, 1'b1, 1'b0, -1);
        add(16'hBF00, 1'b1, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, -1);
        add(16'h0000, 1'b1, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 2);
        add(16'h8000, 1'b0, 3'd2, 32'h0000_0000, 1'b0, 1'b0, 2);
        add(16'h0001, 1'b1, 3'd3, 32'h0000_0001, 1'b0, 1'b1, 2);
        add(16'h0001, 1'b1, 3'd0, 32'h0000_0000, 1'b0, 1'b1, -1);
        add(16'h3E80, 1'b1, 3'd0, 32'h0000_0000, 1'b0, 1'b1, 2);
        add(16'h3E80, 1'b0, 3'd3, 32'h0000_0001, 1'b0, 1'b1, -1);
        add(16'hBF80, 1'b0, 3'd0, 32'h0000_0000, 1'b1, 1'b0, -1);
        add(16'h4F80, 1'b0, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 2);
        add(16'hC2F7, 1'b1, 3'd0, 32'hFFFF_FF84, 1'b0, 1'b1, 3);
        add(16'hC2F7, 1'b1, 3'd2, 32'hFFFF_FF84, 1'b0, 1'b1, -1);
        add(16'hC2F7, 1'b1, 3'd1, 32'hFFFF_FF85, 1'b0, 1'b1, -1);
        add(16'h3F00, 1'b1, 3'd0, 32'h0000_0000, 1'b0, 1'b1, -1);
        add(16'h3FE0, 1'b1, 3'd0, 32'h0000_0002, 1'b0, 1'b1, -1);
        add(16'h3F80, 1'b0, 3'd0, 32'h0000_0001, 1'b0, 1'b0, -1);

        #12;
        check("reset ready_o", 32'(bus.ready_o), 32'd1);
        check("reset valid_o", 32'(bus.valid_o), 32'd0);
        check("reset result_o", bus.result_o, 32'd0);
        check("reset flags", {30'd0, bus.nv_o, bus.nx_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].sgn, vecs[i].rm, got, res, nv, nx, lat);
            check($sformatf("v%0d %04h valid", i, vecs[i].op), 32'(got), 32'd1);
            check($sformatf("v%0d %04h result", i, vecs[i].op), res, vecs[i].res);
            check($sformatf("v%0d %04h nv", i, vecs[i].op), 32'(nv), 32'(vecs[i].nv));
            check($sformatf("v%0d %04h nx", i, vecs[i].op), 32'(nx), 32'(vecs[i].nx));
            if (vecs[i].lat >= 0) begin
                check($sformatf("v%0d %04h latency", i, vecs[i].op), 32'(lat),
                      32'(vecs[i].lat));
            end
            @(posedge clk); #1;
            check($sformatf("v%0d idle after handshake", i), 32'(bus.ready_o), 32'd1);
        end

        // Backpressure: hold ready_i low for three cycles in DONE.
        bus.ready_i = 1'b0;
        run_op(16'h4049, 1'b1, 3'd0, got, res, nv, nx, lat);
        check("bp valid", 32'(got), 32'd1);
        for (int c = 0; c < 3; c++) begin
            bus.valid_i   = (c == 0);
            bus.operand_i = 16'h3F80;
            @(posedge clk); #1;
            check($sformatf("bp c%0d valid_o", c), 32'(bus.valid_o), 32'd1);
            check($sformatf("bp c%0d result", c), bus.result_o, 32'h0000_0003);
            check($sformatf("bp c%0d flags", c), {30'd0, bus.nv_o, bus.nx_o}, 32'd1);
            check($sformatf("bp c%0d ready_o", c), 32'(bus.ready_o), 32'd0);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp release valid_o", 32'(bus.valid_o), 32'd0);
        check("bp release ready_o", 32'(bus.ready_o), 32'd1);
        @(posedge clk); #1;
        check("bp pulse ignored", 32'(bus.ready_o), 32'd1);
        run_op(16'h3F80, 1'b1, 3'd0, got, res, nv, nx, lat);
        check("bp next valid", 32'(got), 32'd1);
        check("bp next result", res, 32'h0000_0001);
        check("bp next flags", {30'd0, nv, nx}, 32'd0);
        @(posedge clk); #1;

        // Reset during the long left-shift of 2^31 unsigned.
        bus.valid_i   = 1'b1;
        bus.operand_i = 16'h4F00;
        bus.signed_i  = 1'b0;
        bus.rm_i      = 3'd0;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst valid_o", 32'(bus.valid_o), 32'd0);
        check("rst ready_o", 32'(bus.ready_o), 32'd1);
        check("rst result_o", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (bus.valid_o) stray = 1'b1;
        end
        check("rst no stray valid", 32'(stray), 32'd0);
        run_op(16'hC040, 1'b1, 3'd0, got, res, nv, nx, lat);
        check("post-rst valid", 32'(got), 32'd1);
        check("post-rst result", res, 32'hFFFF_FFFD);
        check("post-rst flags", {30'd0, nv, nx}, 32'd0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
